// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default bus widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   APB_DATA_WIDTH / APB_ADDR_WIDTH / APB_TIMEOUT_CYCLES - defaults shared with the responder
//   apb_state_t and APB_IDLE/APB_SETUP/APB_ACCESS        - requester FSM encoding
//   apb_cnt_width()                                      - width of a wait counter
package apb_pkg;

    localparam int APB_DATA_WIDTH     = 32;
    localparam int APB_ADDR_WIDTH     = 10;
    localparam int APB_TIMEOUT_CYCLES = 16;

    typedef logic [1:0] apb_state_t;

    localparam apb_state_t APB_IDLE   = 2'd0;
    localparam apb_state_t APB_SETUP  = 2'd1;
    localparam apb_state_t APB_ACCESS = 2'd2;

    // Bits needed to hold 0 .. limit-1; never less than one bit.
    function automatic int apb_cnt_width(input int limit);
        return (limit <= 2) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait counter with an expiry flag for the APB requester.
// Latency: count updates one edge after clr/inc; expired is combinational from the count.
// Backpressure: none; the counter saturates at its limit until cleared.
//
// Ports:
//   Pclk, Prst  - clock, asynchronous active-high reset
//   clr         - restart counting from zero (held during SETUP)
//   inc         - one more ACCESS cycle without Pready
//   expired     - count has reached TIMEOUT_CYCLES-1
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
    input  logic Pclk,
    input  logic Prst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CW = apb_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    assign expired = (count == LIMIT);

    always_ff @(posedge Pclk or posedge Prst) begin
        if (Prst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !expired) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/apb_master_req.sv
// APB requester: turns a valid/ready command into one SETUP+ACCESS transfer at a time.
// Latency: accept at edge 0, SETUP cycle 1, ACCESS from cycle 2; rsp_valid one cycle after the Pready edge.
// Backpressure: cmd_ready is high only in IDLE; a new command can be taken in the rsp_valid cycle.
//
// Optional build macro: APB_TIMEOUT_EN - abort an ACCESS phase that waits TIMEOUT_CYCLES
// cycles without Pready, reporting rsp_err=1 and rsp_rdata=0.
//
// Ports:
//   Pclk, Prst                                  - clock, asynchronous active-high reset
//   cmd_valid/cmd_ready, cmd_write/addr/wdata   - command port, sampled only at accept
//   rsp_valid, rsp_rdata, rsp_err               - one-cycle response strobe with data/status
//   Psel, Pena, Pwrite, Paddr, Pwdata           - registered APB request outputs
//   Prdata, Pready, Perr                        - APB responder inputs, used only in ACCESS
module apb_master_req
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int ADDRESS_WIDTH  = APB_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
    input  logic                     Pclk,
    input  logic                     Prst,

    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]    cmd_wdata,

    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_err,

    output logic                     Psel,
    output logic                     Pena,
    output logic                     Pwrite,
    output logic [ADDRESS_WIDTH-1:0] Paddr,
    output logic [DATA_WIDTH-1:0]    Pwdata,
    input  logic [DATA_WIDTH-1:0]    Prdata,
    input  logic                     Pready,
    input  logic                     Perr
);

    // The wait counter needs at least two values to tell "first ACCESS cycle" from "expired".
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
        $error("apb_master_req: TIMEOUT_CYCLES must be at least 2");
    end

    apb_state_t state;

    // Only IDLE can take a command; derived from state so it needs no extra flop.
    assign cmd_ready = (state == APB_IDLE);

`ifdef APB_TIMEOUT_EN
    logic wait_expired;

    // Counting restarts in SETUP, so every ACCESS phase begins from zero.
    apb_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .Pclk    (Pclk),
        .Prst    (Prst),
        .clr     (state == APB_SETUP),
        .inc     ((state == APB_ACCESS) && !Pready),
        .expired (wait_expired)
    );
`endif

    always_ff @(posedge Pclk or posedge Prst) begin
        if (Prst) begin
            state     <= APB_IDLE;
            Psel      <= 1'b0;
            Pena      <= 1'b0;
            Pwrite    <= 1'b0;
            Paddr     <= '0;
            Pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            // The response strobe lasts exactly one cycle; rsp_rdata/rsp_err keep their value.
            rsp_valid <= 1'b0;

            case (state)
                APB_IDLE: begin
                    if (cmd_valid) begin
                        Pwrite <= cmd_write;
                        Paddr  <= cmd_addr;
                        Pwdata <= cmd_wdata;
                        Psel   <= 1'b1;
                        Pena   <= 1'b0;
                        state  <= APB_SETUP;
                    end else begin
                        // Address/data/direction deliberately keep their last values.
                        Psel <= 1'b0;
                        Pena <= 1'b0;
                    end
                end

                APB_SETUP: begin
                    // Pready/Perr here belong to nobody; SETUP always lasts one cycle.
                    Pena  <= 1'b1;
                    state <= APB_ACCESS;
                end

                APB_ACCESS: begin
                    if (Pready) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= Pwrite ? '0 : Prdata;
                        rsp_err   <= Perr;
                        Psel      <= 1'b0;
                        Pena      <= 1'b0;
                        state     <= APB_IDLE;
                    end
`ifdef APB_TIMEOUT_EN
                    // Pready on the expiry edge takes priority over the abort.
                    else if (wait_expired) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        Psel      <= 1'b0;
                        Pena      <= 1'b0;
                        state     <= APB_IDLE;
                    end
`endif
                end

                default: begin
                    Psel  <= 1'b0;
                    Pena  <= 1'b0;
                    state <= APB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_req.sv
// Bench for apb_master_req: directed transfers plus random traffic against a transaction model.
// Latency: n/a.
// Backpressure: the bench plays the APB responder and the command source.
module tb_apb_master_req;

    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int TMO = 16;

    logic          Pclk;
    logic          Prst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          Psel;
    logic          Pena;
    logic          Pwrite;
    logic [AW-1:0] Paddr;
    logic [DW-1:0] Pwdata;
    logic [DW-1:0] Prdata;
    logic          Pready;
    logic          Perr;

    apb_master_req #(
        .DATA_WIDTH     (DW),
        .ADDRESS_WIDTH  (AW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .Pclk      (Pclk),
        .Prst      (Prst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .Psel      (Psel),
        .Pena      (Pena),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Prdata    (Prdata),
        .Pready    (Pready),
        .Perr      (Perr)
    );

    initial begin
        Pclk = 1'b0;
        forever #5 Pclk = ~Pclk;
    end

    int n_vec = 0;
    int n_mis = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: a transfer is "busy" from its accept edge; age counts edges
    // since accept, so age 1 is the SETUP cycle and age n>=2 is ACCESS cycle n-1.
    bit          m_busy;
    int          m_age;
    bit          m_write;
    bit [AW-1:0] m_addr;
    bit [DW-1:0] m_wdata;
    bit          m_rsp_v;
    bit [DW-1:0] m_rdata;
    bit          m_err;

    always @(posedge Pclk or posedge Prst) begin
        if (Prst) begin
            m_busy  <= 1'b0;
            m_age   <= 0;
            m_write <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_rsp_v <= 1'b0;
            m_rdata <= '0;
            m_err   <= 1'b0;
        end else begin
            m_rsp_v <= 1'b0;
            if (!m_busy) begin
                if (cmd_valid) begin
                    m_busy  <= 1'b1;
                    m_age   <= 1;
                    m_write <= cmd_write;
                    m_addr  <= cmd_addr;
                    m_wdata <= cmd_wdata;
                end
            end else if (m_age >= 2 && Pready) begin
                m_busy  <= 1'b0;
                m_rsp_v <= 1'b1;
                m_rdata <= m_write ? '0 : Prdata;
                m_err   <= Perr;
            end
`ifdef APB_TIMEOUT_EN
            else if (m_age - 1 == TMO) begin
                m_busy  <= 1'b0;
                m_rsp_v <= 1'b1;
                m_rdata <= '0;
                m_err   <= 1'b1;
            end
`endif
            else begin
                m_age <= m_age + 1;
            end
        end
    end

    // Single compare process: every cycle outside reset, mid-cycle.
    always @(negedge Pclk) begin
        if (chk_en && !Prst) begin
            chk("cmd_ready", 64'(cmd_ready), 64'(!m_busy));
            chk("Psel",      64'(Psel),      64'(m_busy));
            chk("Pena",      64'(Pena),      64'(m_busy && m_age >= 2));
            chk("Pwrite",    64'(Pwrite),    64'(m_write));
            chk("Paddr",     64'(Paddr),     64'(m_addr));
            chk("Pwdata",    64'(Pwdata),    64'(m_wdata));
            chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp_v));
            if (m_rsp_v) begin
                chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
                chk("rsp_err",   64'(rsp_err),   64'(m_err));
            end
        end
    end

    task automatic step();
        @(negedge Pclk);
    endtask

    task automatic idle_inputs();
        cmd_valid = 1'b0;
        Pready    = 1'b0;
        Perr      = 1'b0;
    endtask

    // Issue one command at the current negedge (DUT must be idle) and play the responder:
    // Pready stays low for 'lo' ACCESS cycles, then rises. With 'stale', Pready is also high
    // before ACCESS. Returns in the rsp_valid cycle, so a following call is back-to-back.
    task automatic xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int lo, input bit stale, input bit pe, input logic [DW-1:0] prd,
                        input bit keep_valid, output int lat, output int nsel, output int nena);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        Pready    = stale;
        Perr      = pe;
        Prdata    = prd;
        lat  = -1;
        nsel = 0;
        nena = 0;
        for (int c = 1; c <= 64; c++) begin
            step();
            // Command fields change while busy; the DUT must ignore them.
            cmd_valid = keep_valid;
            cmd_write = 1'($urandom);
            cmd_addr  = AW'($urandom);
            cmd_wdata = $urandom;
            if (Psel) nsel++;
            if (Pena) nena++;
            Pready = (c >= 2 + lo) || (stale && c < 2);
            if (rsp_valid) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) chk("xfer_complete", 64'(0), 64'(1));
    endtask

    int lat, nsel, nena;

    initial begin
        Prst = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        Prdata    = '0;
        idle_inputs();
        repeat (3) step();

        chk("rst_Psel",      64'(Psel),      64'(0));
        chk("rst_Pena",      64'(Pena),      64'(0));
        chk("rst_Pwrite",    64'(Pwrite),    64'(0));
        chk("rst_Paddr",     64'(Paddr),     64'(0));
        chk("rst_Pwdata",    64'(Pwdata),    64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        chk("rst_rsp_err",   64'(rsp_err),   64'(0));

        Prst = 1'b0;
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk_en = 1'b1;
        step();

        // Write, responder with one registered wait: Psel cycles 1-3, Pena 2-3, rsp in cycle 4.
        xfer(1'b1, 10'h005, 32'hDEADBEEF, 1, 1'b0, 1'b0, 32'h1234_5678, 1'b0, lat, nsel, nena);
        chk("wr_latency",  64'(lat),  64'(4));
        chk("wr_psel_cyc", 64'(nsel), 64'(3));
        chk("wr_pena_cyc", 64'(nena), 64'(2));
        chk("wr_rdata",    64'(rsp_rdata), 64'(0));
        chk("wr_err",      64'(rsp_err),   64'(0));
        idle_inputs();
        step();

        // Read with three wait cycles: four ACCESS cycles.
        xfer(1'b0, 10'h005, 32'h0, 3, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, lat, nsel, nena);
        chk("rd_latency",  64'(lat),  64'(6));
        chk("rd_pena_cyc", 64'(nena), 64'(4));
        chk("rd_rdata",    64'(rsp_rdata), 64'(32'hDEADBEEF));
        idle_inputs();
        step();

        // Error read answered in the first ACCESS cycle, then a write accepted in the rsp cycle.
        xfer(1'b0, 10'h03A, 32'h0, 0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, lat, nsel, nena);
        chk("err_latency",   64'(lat),       64'(3));
        chk("err_flag",      64'(rsp_err),   64'(1));
        chk("err_rdata",     64'(rsp_rdata), 64'(32'hCAFE_F00D));
        chk("err_cmd_ready", 64'(cmd_ready), 64'(1));
        xfer(1'b1, 10'h007, 32'h0BAD_CAFE, 1, 1'b0, 1'b0, 32'h0, 1'b0, lat, nsel, nena);
        chk("after_err_latency", 64'(lat), 64'(4));
        idle_inputs();
        step();

        // Back-to-back writes with cmd_valid held high throughout.
        xfer(1'b1, 10'h001, 32'h1111_1111, 1, 1'b0, 1'b0, 32'h0, 1'b1, lat, nsel, nena);
        chk("b2b1_latency", 64'(lat), 64'(4));
        xfer(1'b1, 10'h002, 32'h2222_2222, 1, 1'b0, 1'b0, 32'h0, 1'b0, lat, nsel, nena);
        chk("b2b2_latency", 64'(lat), 64'(4));
        idle_inputs();
        step();

        // Stale Pready during IDLE and SETUP must not shorten the transfer.
        xfer(1'b0, 10'h155, 32'h0, 0, 1'b1, 1'b0, 32'h5A5A_A5A5, 1'b0, lat, nsel, nena);
        chk("stale_latency",  64'(lat),  64'(3));
        chk("stale_pena_cyc", 64'(nena), 64'(1));
        idle_inputs();
        step();

`ifdef APB_TIMEOUT_EN
        // Pready stuck low: abort after TMO ACCESS cycles.
        xfer(1'b0, 10'h2AA, 32'h0, 1000, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, lat, nsel, nena);
        chk("tmo_latency",  64'(lat),       64'(TMO + 2));
        chk("tmo_pena_cyc", 64'(nena),      64'(TMO));
        chk("tmo_err",      64'(rsp_err),   64'(1));
        chk("tmo_rdata",    64'(rsp_rdata), 64'(0));
        idle_inputs();
        step();
`endif

        // Reset asserted mid-ACCESS: outputs drop without a clock edge.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 10'h0F0;
        cmd_wdata = 32'h7777_7777;
        step();
        idle_inputs();
        step();
        step();
        chk("mid_Pena_before_rst", 64'(Pena), 64'(1));
        #2;
        Prst = 1'b1;
        #1;
        chk("arst_Psel",      64'(Psel),      64'(0));
        chk("arst_Pena",      64'(Pena),      64'(0));
        chk("arst_rsp_valid", 64'(rsp_valid), 64'(0));
        step();
        Pready = 1'b1;
        step();
        Prst = 1'b0;
        repeat (4) step();
        idle_inputs();
        step();

        // Random traffic checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_write = 1'($urandom);
            cmd_addr  = AW'($urandom);
            cmd_wdata = $urandom;
            Pready    = ($urandom_range(0, 2) == 0);
            Perr      = ($urandom_range(0, 3) == 0);
            Prdata    = $urandom;
            step();
        end
        idle_inputs();
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

endmodule
